col_bram_loader: RTL and testbench
==================================

Name: col_bram_loader

Overview:
- Write-side controller for the ping/pong column BRAM that holds matrix B, transposed.
- Takes a 512-bit AXI-Stream of columns from the DDR/TB side, one column per beat.
- Drives BRAM port A (ena/wea/addra/dina) into the bank currently selected for filling.
- Owns ping_pong_sel and its 3-cycle-delayed copy, and hands completed matrices to the DSP compute engine with a valid/done handshake.

Parameters:
- NUM_BRAM, 8, number of BRAMs per bank (one enable bit each)
- BRAM_DATA_WIDTH, 64, width of each BRAM
- ADDR_WIDTH, 9, BRAM address width
- NUM_COLS, 512, columns per matrix (beats per fill); must be in 1..2**ADDR_WIDTH
- Localparam DATA_WIDTH = NUM_BRAM*BRAM_DATA_WIDTH (512)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- s_axis_tdata  in  DATA_WIDTH  one matrix column
- s_axis_tvalid  in  1  beat valid
- s_axis_tlast  in  1  last column of matrix (checked only)
- s_axis_tready  out  1  loader accepts beat
- bram_ena  out  NUM_BRAM  port A enable, all bits equal
- bram_wea  out  NUM_BRAM  port A write enable, all bits equal
- bram_addra  out  ADDR_WIDTH  port A address
- bram_dina  out  DATA_WIDTH  port A data
- ping_pong_sel  out  1  0 = fill ping/read pong; 1 = fill pong/read ping
- ping_pong_sel_d3  out  1  ping_pong_sel delayed 3 cycles (read-data mux select)
- mat_valid  out  1  read bank holds a complete matrix for compute
- mat_done  in  1  one-cycle pulse from compute: finished reading read bank
- tlast_err  out  1  sticky tlast-mismatch flag
- mat_count  out  16  matrices handed to compute, wraps at 2**16

Behaviour:
- Reset (async assert, sync release): state=FILL, col counter=0. All outputs are 0: tready, ena, wea, addra, dina, sel, sel_d3 pipe, mat_valid, tlast_err, mat_count.
- FILL state:
  - s_axis_tready=1.
  - Beat accepted (tvalid&tready) at cycle t → at t+1: bram_ena=bram_wea=all ones, bram_addra=counter value at t, bram_dina=tdata. Otherwise ena/wea=0, addr and data hold.
  - The counter increments per accepted beat. tvalid gaps stall it, so addresses stay contiguous.
  - Accepting beat NUM_COLS-1 moves the state to FULL and resets the counter to 0.
- FULL state:
  - s_axis_tready=0.
  - Swap condition: (mat_valid==0) or (mat_done==1) in the same cycle.
  - On swap: ping_pong_sel toggles (registered), mat_valid←1, mat_count+1, state←FILL.
  - FULL lasts at least 1 cycle. The last write lands at t+1 under the old sel; sel toggles no earlier than t+2.
- mat_valid:
  - Clears the cycle after mat_done when no swap happens that cycle.
  - mat_done coincident with a swap leaves mat_valid=1 (new matrix).
  - mat_done while mat_valid=0 is ignored.
- ping_pong_sel_d3 is a 3-stage register pipe of ping_pong_sel. It matches the port-B read latency of 3.
- tlast checking:
  - tlast must be high exactly on beat NUM_COLS-1.
  - Any mismatch (early or missing) sets tlast_err, cleared only by reset.
  - The counter is authoritative; the fill continues.
- NUM_COLS=1: every accepted beat completes a matrix.
- Compute never reads the fill bank. Swapping only on FULL plus consumer-free guarantees no overwrite of an unconsumed matrix.
- Reset mid-fill discards the partial matrix and returns to FILL on ping (sel=0).

Decomposition:
- Package col_bram_pkg:
  - localparams DATA_WIDTH, NUM_BRAM, BRAM_DATA_WIDTH, ADDR_WIDTH, READ_LATENCY=3.
  - typedef enum logic {FILL, FULL} loader_state_t.
  - The same package serves the col_bram instance.
- One natural sub-module: sel_delay_pipe, a parameterised N-stage delay with async reset, used for ping_pong_sel_d3 (N=READ_LATENCY).

Test Plan:
- Reset: assert rst mid-cycle → all outputs 0 immediately; after release tready=1, sel=0, mat_valid=0.
- Basic fill (NUM_COLS=4, tdata=0xA0..0xA3, tlast on beat 3):
  - addra 0,1,2,3 with ena=wea=8'hFF, each one cycle after its beat.
  - sel→1 two cycles after the last beat; mat_valid=1, mat_count=1.
  - sel_d3→1 three cycles after sel.
- Back-to-back with backpressure: second 4-column matrix while mat_valid=1 (no mat_done).
  - Writes go to pong (sel=1); tready=0 after the 4th beat; sel holds.
  - Pulse mat_done → sel→0 next cycle, mat_valid stays 1, mat_count=2.
- tvalid gaps: tvalid pattern 1,0,0,1,0,1,1 on a 4-column matrix → addra strictly 0,1,2,3, and ena only on accepted beats.
- tlast error: tlast high on beat 1 of 4 → tlast_err=1 next cycle; fill still completes at beat 3; flag persists until rst.
- Reset mid-fill: rst after 2 of 4 beats with sel=1 → sel=0, mat_valid=0. The next fill starts at addra=0 on ping.

Source files
------------

// File: rtl/col_bram_pkg.sv
// rtl/col_bram_pkg.sv - shared geometry and types for the column BRAM and its write-side loader
package col_bram_pkg;

    localparam int NUM_BRAM        = 8;
    localparam int BRAM_DATA_WIDTH = 64;
    localparam int DATA_WIDTH      = NUM_BRAM * BRAM_DATA_WIDTH;
    localparam int ADDR_WIDTH      = 9;
    localparam int READ_LATENCY    = 3;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_t;

endpackage

// File: rtl/sel_delay_pipe.sv
// rtl/sel_delay_pipe.sv - N-stage register delay with asynchronous reset
module sel_delay_pipe #(
    parameter int N     = 3,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < N; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[N-1];

endmodule

// File: rtl/col_bram_loader.sv
// rtl/col_bram_loader.sv - streams matrix columns into the fill bank of a ping/pong BRAM
// and hands each completed matrix to compute with a valid/done handshake.
module col_bram_loader #(
    parameter int NUM_BRAM        = col_bram_pkg::NUM_BRAM,
    parameter int BRAM_DATA_WIDTH = col_bram_pkg::BRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH      = col_bram_pkg::ADDR_WIDTH,
    parameter int NUM_COLS        = 512,
    localparam int DATA_WIDTH     = NUM_BRAM * BRAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [NUM_BRAM-1:0]   bram_ena,
    output logic [NUM_BRAM-1:0]   bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [DATA_WIDTH-1:0] bram_dina,
    output logic                  ping_pong_sel,
    output logic                  ping_pong_sel_d3,
    output logic                  mat_valid,
    input  logic                  mat_done,
    output logic                  tlast_err,
    output logic [15:0]           mat_count
);

    import col_bram_pkg::loader_state_t;
    import col_bram_pkg::FILL;
    import col_bram_pkg::FULL;
    import col_bram_pkg::READ_LATENCY;

    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(NUM_COLS - 1);

    loader_state_t         state;
    loader_state_t         state_next;
    logic [ADDR_WIDTH-1:0] col_cnt;
    logic                  accept;
    logic                  last_col;
    logic                  swap;

    assign accept   = s_axis_tvalid && s_axis_tready;
    assign last_col = (col_cnt == LAST_COL);
    // Compute is free once it holds nothing or is releasing its matrix this very cycle.
    assign swap     = (state == FULL) && (!mat_valid || mat_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (accept && last_col) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (swap) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        s_axis_tready = 1'b0;
        if (!rst && state == FILL) begin
            s_axis_tready = 1'b1;
        end
    end

    // Column counter only advances on accepted beats, so tvalid gaps never leave address holes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
        end else if (accept) begin
            if (last_col) begin
                col_cnt <= '0;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bram_ena   <= '0;
            bram_wea   <= '0;
            bram_addra <= '0;
            bram_dina  <= '0;
        end else begin
            bram_ena <= {NUM_BRAM{accept}};
            bram_wea <= {NUM_BRAM{accept}};
            if (accept) begin
                bram_addra <= col_cnt;
                bram_dina  <= s_axis_tdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tlast_err <= 1'b0;
        end else if (accept && (s_axis_tlast != last_col)) begin
            tlast_err <= 1'b1;
        end
    end

    // A swap always publishes a fresh matrix, so it wins over a coincident mat_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ping_pong_sel <= 1'b0;
            mat_valid     <= 1'b0;
            mat_count     <= '0;
        end else if (swap) begin
            ping_pong_sel <= ~ping_pong_sel;
            mat_valid     <= 1'b1;
            mat_count     <= mat_count + 16'd1;
        end else if (mat_done && mat_valid) begin
            mat_valid <= 1'b0;
        end
    end

    sel_delay_pipe #(
        .N     (READ_LATENCY),
        .WIDTH (1)
    ) u_sel_delay (
        .clk (clk),
        .rst (rst),
        .d   (ping_pong_sel),
        .q   (ping_pong_sel_d3)
    );

endmodule

// File: tb/tb_col_bram_loader.sv
// tb/tb_col_bram_loader.sv - randomized self-checking bench for col_bram_loader
module tb_col_bram_loader;

    localparam int NB = 8;
    localparam int BW = 64;
    localparam int AW = 9;
    localparam int NC = 4;
    localparam int DW = NB * BW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [NB-1:0] bram_ena;
    logic [NB-1:0] bram_wea;
    logic [AW-1:0] bram_addra;
    logic [DW-1:0] bram_dina;
    logic          ping_pong_sel;
    logic          ping_pong_sel_d3;
    logic          mat_valid;
    logic          mat_done;
    logic          tlast_err;
    logic [15:0]   mat_count;

    always #5 clk = ~clk;

    col_bram_loader #(
        .NUM_BRAM        (NB),
        .BRAM_DATA_WIDTH (BW),
        .ADDR_WIDTH      (AW),
        .NUM_COLS        (NC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tready    (s_axis_tready),
        .bram_ena         (bram_ena),
        .bram_wea         (bram_wea),
        .bram_addra       (bram_addra),
        .bram_dina        (bram_dina),
        .ping_pong_sel    (ping_pong_sel),
        .ping_pong_sel_d3 (ping_pong_sel_d3),
        .mat_valid        (mat_valid),
        .mat_done         (mat_done),
        .tlast_err        (tlast_err),
        .mat_count        (mat_count)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: columns held in the current fill, whether a full matrix waits for compute,
    // which bank is being filled, and a short history of bank selects.
    int            m_beats;
    bit            m_full;
    bit            m_sel;
    bit            m_valid;
    bit            m_err;
    bit            m_wr;
    bit            m_sel_hist [3];
    int unsigned   m_count;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_beats = 0;
        m_full  = 0;
        m_sel   = 0;
        m_valid = 0;
        m_err   = 0;
        m_wr    = 0;
        m_count = 0;
        m_addr  = '0;
        m_data  = '0;
        for (int i = 0; i < 3; i++) m_sel_hist[i] = 0;
    endtask

    task automatic model_step();
        bit took;
        m_sel_hist[2] = m_sel_hist[1];
        m_sel_hist[1] = m_sel_hist[0];
        m_sel_hist[0] = m_sel;
        took = s_axis_tvalid && !m_full;
        if (m_full) begin
            if (!m_valid || mat_done) begin
                m_sel   = !m_sel;
                m_valid = 1;
                m_count = (m_count + 1) % 65536;
                m_full  = 0;
            end
        end else if (mat_done) begin
            m_valid = 0;
        end
        m_wr = took;
        if (took) begin
            m_addr = AW'(m_beats);
            m_data = s_axis_tdata;
            if (s_axis_tlast != (m_beats == NC - 1)) m_err = 1;
            m_beats++;
            if (m_beats == NC) begin
                m_beats = 0;
                m_full  = 1;
            end
        end
    endtask

    task automatic check_outputs();
        check("tready", s_axis_tready, !m_full);
        check("ena", bram_ena, {NB{m_wr}});
        check("wea", bram_wea, {NB{m_wr}});
        check("addra", bram_addra, m_addr);
        check("dina", bram_dina, m_data);
        check("sel", ping_pong_sel, m_sel);
        check("sel_d3", ping_pong_sel_d3, m_sel_hist[2]);
        check("mat_valid", mat_valid, m_valid);
        check("tlast_err", tlast_err, m_err);
        check("mat_count", mat_count, m_count[15:0]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit l, input bit done);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        mat_done      = done;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, 0, 0);
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic do_reset_mid_cycle();
        s_axis_tvalid = 0;
        mat_done      = 0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_tready", s_axis_tready, 0);
        check("rst_ena", bram_ena, 0);
        check("rst_wea", bram_wea, 0);
        check("rst_addra", bram_addra, 0);
        check("rst_dina", bram_dina, 0);
        check("rst_sel", ping_pong_sel, 0);
        check("rst_sel_d3", ping_pong_sel_d3, 0);
        check("rst_mat_valid", mat_valid, 0);
        check("rst_tlast_err", tlast_err, 0);
        check("rst_mat_count", mat_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs();
    endtask

    logic [AW-1:0] seen_addr [$];
    bit            gap_pat [7] = '{1, 0, 0, 1, 0, 1, 1};

    initial begin
        rst           = 1'b1;
        s_axis_tvalid = 0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 0;
        mat_done      = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_reset_mid_cycle();

        // Basic fill into ping
        for (int i = 0; i < NC; i++) drive(1, DW'(8'hA0 + i), i == NC - 1, 0);
        idle(4);
        check("basic_sel", ping_pong_sel, 1);
        check("basic_sel_d3", ping_pong_sel_d3, 1);
        check("basic_valid", mat_valid, 1);
        check("basic_count", mat_count, 1);

        // Second matrix into pong while compute still holds the first
        for (int i = 0; i < NC; i++) drive(1, DW'(8'hB0 + i), i == NC - 1, 0);
        idle(3);
        check("bp_tready", s_axis_tready, 0);
        check("bp_sel_hold", ping_pong_sel, 1);
        drive(0, '0, 0, 1);
        check("bp_sel_swap", ping_pong_sel, 0);
        check("bp_valid", mat_valid, 1);
        check("bp_count", mat_count, 2);
        drive(0, '0, 0, 1);
        idle(1);
        check("bp_valid_clr", mat_valid, 0);

        // tvalid gaps: addresses stay contiguous
        seen_addr.delete();
        for (int i = 0; i < 7; i++) begin
            drive(gap_pat[i], rand_data(), gap_pat[i] && (m_beats == NC - 1), 0);
            if (bram_ena[0]) seen_addr.push_back(bram_addra);
        end
        check("gap_nwrites", seen_addr.size(), NC);
        for (int i = 0; i < NC && i < seen_addr.size(); i++) check("gap_addr", seen_addr[i], i);
        idle(2);

        // Early tlast on beat 1
        for (int i = 0; i < NC; i++) drive(1, rand_data(), i == 1, 0);
        check("tlast_err_set", tlast_err, 1);
        idle(2);
        drive(0, '0, 0, 1);
        drive(0, '0, 0, 1);
        idle(2);
        check("tlast_err_sticky", tlast_err, 1);

        // Fill that publishes immediately (sel goes to 1), then reset partway through the next
        for (int i = 0; i < NC; i++) drive(1, rand_data(), i == NC - 1, 0);
        idle(2);
        check("pre_rst_sel", ping_pong_sel, 1);
        drive(1, rand_data(), 0, 0);
        drive(1, rand_data(), 0, 0);
        do_reset_mid_cycle();
        drive(1, DW'(8'hC0), 0, 0);
        check("post_rst_addr", bram_addra, 0);
        check("post_rst_sel", ping_pong_sel, 0);
        check("post_rst_ena", bram_ena, 8'hFF);

        // Randomized traffic with occasional tlast errors and random consumer timing
        for (int i = 0; i < 3000; i++) begin
            bit v;
            bit l;
            v = ($urandom_range(0, 3) != 0);
            l = (m_beats == NC - 1);
            if ($urandom_range(0, 31) == 0) l = !l;
            drive(v, rand_data(), l, $urandom_range(0, 5) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
